// File: rtl/arm_inst_encoder_pkg.sv
// Shared ISA constants, field bundle and loader FSM states for the ARM-subset pipeline.
// The control decoder imports the same mode/opcode constants so both sides agree on encodings.
package arm_inst_encoder_pkg;

    localparam logic [1:0] ARITHMETIC = 2'd0;
    localparam logic [1:0] MEMOP      = 2'd1;
    localparam logic [1:0] BR         = 2'd2;

    localparam logic [3:0] OP_AND     = 4'd0;
    localparam logic [3:0] OP_EOR     = 4'd1;
    localparam logic [3:0] OP_SUB     = 4'd2;
    localparam logic [3:0] OP_ADD     = 4'd4;
    localparam logic [3:0] OP_ADC     = 4'd5;
    localparam logic [3:0] OP_SBC     = 4'd6;
    localparam logic [3:0] OP_TST     = 4'd8;
    localparam logic [3:0] OP_CMP     = 4'd10;
    localparam logic [3:0] OP_ORR     = 4'd12;
    localparam logic [3:0] OP_MOV     = 4'd13;
    localparam logic [3:0] OP_MVN     = 4'd15;
    localparam logic [3:0] OP_LDR_STR = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0]  cond;
        logic [1:0]  mode;
        logic [3:0]  opcode;
        logic        s;
        logic        i;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] shift_op;
        logic [23:0] imm24;
    } bundle_t;

    function automatic logic is_legal_alu_op(input logic [3:0] op);
        case (op)
            OP_AND, OP_EOR, OP_SUB, OP_ADD, OP_ADC, OP_SBC,
            OP_TST, OP_CMP, OP_ORR, OP_MOV, OP_MVN: is_legal_alu_op = 1'b1;
            default:                                is_legal_alu_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arm_inst_encoder_if.sv
// Field-bundle handshake plus instruction-memory write port of the program loader.
// master = bundle producer / memory side, slave = the encoder.
interface arm_inst_encoder_if #(parameter int ADDR_W = 8);

    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [3:0]        cond;
    logic [1:0]        mode;
    logic [3:0]        opcode;
    logic              s;
    logic              i;
    logic [3:0]        rn;
    logic [3:0]        rd;
    logic [11:0]       shift_op;
    logic [23:0]       imm24;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_last, cond, mode, opcode, s, i, rn, rd, shift_op, imm24,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_last, cond, mode, opcode, s, i, rn, rd, shift_op, imm24,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arm_inst_encoder_inst_packer.sv
// Combinational field-to-word packer; flags mode 3 and opcodes outside the legal set.
// Zero latency, no flow control of its own.
module inst_packer
    import arm_inst_encoder_pkg::*;
(
    input  bundle_t     fields,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (fields.mode)
            ARITHMETIC: begin
                word = {fields.cond, 2'b00, fields.i, fields.opcode, fields.s,
                        fields.rn, fields.rd, fields.shift_op};
                // Compare/test only update flags, so S is implied and Rd is unused.
                if (fields.opcode == OP_CMP || fields.opcode == OP_TST) begin
                    word[20]    = 1'b1;
                    word[15:12] = 4'd0;
                end
                illegal = !is_legal_alu_op(fields.opcode);
            end
            MEMOP: begin
                word    = {fields.cond, 2'b01, 1'b0, OP_LDR_STR, fields.s,
                           fields.rn, fields.rd, fields.shift_op};
                illegal = (fields.opcode != OP_LDR_STR);
            end
            BR: begin
                word = {fields.cond, 3'b101, 1'b0, fields.imm24};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/arm_inst_encoder.sv
// Encodes decoded field bundles and writes them to consecutive instruction-memory words.
// Write lands one cycle after accept; in_ready depends on state/count only and drops when full or done.
module arm_inst_encoder
    import arm_inst_encoder_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    arm_inst_encoder_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    bundle_t           fields;
    logic [31:0]       word;
    logic              illegal;
    logic              ready;
    logic              accept;

    always_comb begin
        fields          = '0;
        fields.cond     = bus.cond;
        fields.mode     = bus.mode;
        fields.opcode   = bus.opcode;
        fields.s        = bus.s;
        fields.i        = bus.i;
        fields.rn       = bus.rn;
        fields.rd       = bus.rd;
        fields.shift_op = bus.shift_op;
        fields.imm24    = bus.imm24;
    end

    inst_packer u_packer (
        .fields  (fields),
        .word    (word),
        .illegal (illegal)
    );

    assign ready  = (state_q == LOAD) && (count_q < DEPTH_C);
    assign accept = bus.in_valid && ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = count_q[ADDR_W-1:0];
                        wdata_d = word;
                        count_d = count_q + 1'b1;
                    end
                    // Dropped bundles still end the program if flagged last.
                    if (bus.in_last || (!illegal && (count_q + 1'b1) == DEPTH_C))
                        state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy          = (state_q == LOAD);
    assign done          = (state_q == DONE);
    assign count         = count_q;
    assign err           = err_q;

endmodule

// File: doc/arm_inst_encoder.md
# arm_inst_encoder

Sequential instruction encoder and program loader for the ARM-subset pipeline. It is the write-side counterpart of the ID-stage control decode. It accepts decoded instruction fields one at a time over a valid/ready handshake and packs each into a 32-bit word in the lab's instruction format. It then writes the words to consecutive instruction-memory locations. Testbenches and the boot path use it to load programs before the core is released.

## Interface
Parameters:
- ADDR_W, 8, word-address width of the instruction memory.
- DEPTH, 256, maximum number of words written per load; must be ≤ 2^ADDR_W.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active low.
- start  input  1  pulse: begin a new load at address 0.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  block can accept a bundle this cycle.
- in_last  input  1  final instruction of the program; qualified by accept.
- cond  input  4  condition field.
- mode  input  2  0 arithmetic, 1 memory, 2 branch; 3 is illegal.
- opcode  input  4  ALU opcode; memory mode requires 4.
- s  input  1  set-flags (arithmetic) or load/store select (memory: 1 = LDR).
- i  input  1  immediate flag (arithmetic only).
- rn, rd  input  4 each  register numbers.
- shift_op  input  12  shifter operand / memory offset.
- imm24  input  24  signed branch word offset.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  word address.
- mem_wdata  output  32  encoded word.
- busy  output  1  state is LOAD.
- done  output  1  state is DONE.
- count  output  ADDR_W+1  words written in the current load.
- err  output  1  sticky; set on any dropped bundle, cleared by start or reset.

## Operation
- FSM states: IDLE, LOAD, DONE. Reset enters IDLE.
- IDLE or DONE plus start: go to LOAD, count←0, err←0. start is ignored while in LOAD.
- in_ready = (state==LOAD) && (count < DEPTH). Accept = in_valid && in_ready.
- Encoding for arithmetic mode (mode 0):
  - [31:28]=cond, [27:26]=00, [25]=i, [24:21]=opcode, [20]=s, [19:16]=rn, [15:12]=rd, [11:0]=shift_op.
  - Opcode 10 (CMP) or 8 (TST) forces [20]=1 and [15:12]=0.
  - Legal opcodes are {0,1,2,4,5,6,8,10,12,13,15}.
- Encoding for memory mode (mode 1): [27:26]=01, [25]=0, [24:21]=0100, [20]=s. Remaining fields are placed as in arithmetic mode. opcode≠4 is illegal.
- Encoding for branch mode (mode 2): [31:28]=cond, [27:25]=101, [24]=0, [23:0]=imm24.
- Illegal bundle (mode 3 or illegal opcode): accepted but not written. count is unchanged and err←1. in_last is still honoured.
- Accept with in_last, or a write that makes count==DEPTH: go to DONE after the write.
- A legal accepted bundle is written at mem_addr = count, then count increments.

## Timing
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, count=0, err=0, busy=0, done=0, in_ready=0.
- Latency:
  - A bundle accepted in cycle N is written in cycle N+1: registered mem_we, mem_addr, mem_wdata.
  - count updates at the end of cycle N.
- Throughput is one word per cycle. in_ready is combinational from registered state only; it has no path from in_valid.
- mem_we is a single-cycle pulse per word. Fields are ignored when accept is 0.
- Full: when count reaches DEPTH, in_ready drops the next cycle and the state goes to DONE. A pending in_last is irrelevant.
- start in the same cycle as a final accept: the accept completes, and start is ignored because the state is LOAD.
- Reset mid-load: all registers return to their reset values next edge. Any pending mem_we is cancelled.

## Structure
- The shared package holds:
  - mode constants ARITHMETIC/MEMOP/BR.
  - opcode constants (MOV=13, MVN=15, ADD=4, ADC=5, SUB=2, SBC=6, AND=0, ORR=12, EOR=1, CMP=10, TST=8, LDR/STR=4).
  - FSM state enum.
- These constants are also used by the control decoder.
- Sub-module inst_packer: purely combinational field→word packer that also outputs an illegal flag. The top level holds the FSM, count, and output registers.

## Test plan
- Reset, start, then ADD with cond=E, i=1, s=0, rn=2, rd=1, shift_op=0x005 → next cycle mem_we=1, addr=0, wdata=0xE2821005; count=1.
- CMP with cond=E, i=0, s=0, rn=3, rd=7, shift_op=0x004 → wdata=0xE1530004 (S forced to 1, Rd zeroed).
- LDR with mode=1, s=1, rn=1, rd=0, shift_op=0x008 at addr 1, followed by B with imm24=0xFFFFFE and in_last → words 0xE4910008 and 0xEAFFFFFE at addrs 1 and 2; done=1; in_ready=0.
- mode=3 bundle mid-stream → no mem_we, count unchanged, err=1. The next legal bundle lands at the unskipped address.
- DEPTH=4 with continuous valid → exactly 4 writes (addrs 0–3); in_ready falls; done=1.
- rst_n low during LOAD with valid held → next cycle all outputs are at reset values and no write occurs.
